stream_prefetch_ctrl: RTL

- Sequences a line-granular stream buffer (FIFO of {line_addr, line_data} packets) that sits beside the cache as a sequential prefetcher.
- On a cache miss it checks the buffer head. On a hit it pops the head and returns it. On a miss it flushes the buffer, fetches the demand line from memory, and restarts prefetch at the next line.
- Between misses it keeps the buffer topped up with consecutive lines. It owns the shared memory read port for both demand and prefetch traffic.

---
 rtl/stream_prefetch_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stream_prefetch_ctrl.sv
// Sequential stream-buffer prefetcher: serves cache misses from the buffer head
// or from memory, and keeps the buffer filled with consecutive lines between misses.
module stream_prefetch_ctrl #(
    parameter int ADDR_WIDTH   = 28,
    parameter int LINE_WIDTH   = 128,
    parameter int PACKET_WIDTH = ADDR_WIDTH + LINE_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    miss_i,
    input  logic [ADDR_WIDTH-1:0]   miss_addr_i,
    output logic                    miss_ready_o,
    output logic [LINE_WIDTH-1:0]   miss_data_o,
    output logic                    mem_read_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                    mem_ready_i,
    input  logic [LINE_WIDTH-1:0]   mem_rdata_i,
    output logic                    sb_write_o,
    output logic [PACKET_WIDTH-1:0] sb_packet_o,
    output logic                    sb_read_o,
    output logic                    sb_flush_o,
    input  logic [PACKET_WIDTH-1:0] sb_packet_i,
    input  logic                    sb_full_i,
    input  logic                    sb_empty_i,
    output logic [1:0]              dbg_state_o
);

    // Handshakes: miss_i is a level held until the one-cycle miss_ready_o pulse;
    // mem_read_o/mem_addr_o are held stable until the cycle mem_ready_i is high;
    // sb_write_o/sb_read_o/sb_flush_o are single-cycle strobes, never overlapping.

    typedef enum logic [1:0] {IDLE, LOOKUP, DEMAND, PREFETCH} state_t;

    state_t                  state_r, state_n;
    logic [ADDR_WIDTH-1:0]   req_addr_r, req_addr_n;
    logic [ADDR_WIDTH-1:0]   pf_addr_r, pf_addr_n;
    logic                    pf_active_r, pf_active_n;
    logic                    hit_pend_r, hit_pend_n;

    logic                    miss_ready_n;
    logic [LINE_WIDTH-1:0]   miss_data_n;
    logic                    mem_read_n;
    logic [ADDR_WIDTH-1:0]   mem_addr_n;
    logic                    sb_write_n;
    logic [PACKET_WIDTH-1:0] sb_packet_n;
    logic                    sb_read_n;
    logic                    sb_flush_n;

    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [LINE_WIDTH-1:0]   head_data;
    logic                    head_hit;
    logic                    miss_accept;
    logic                    sb_quiet;

    assign head_addr = sb_packet_i[PACKET_WIDTH-1 -: ADDR_WIDTH];
    assign head_data = sb_packet_i[LINE_WIDTH-1:0];
    assign head_hit  = ~sb_empty_i && (head_addr == req_addr_r);

    // A miss still held high while its response is pending or being signalled
    // must not be accepted a second time.
    assign miss_accept = miss_i && ~hit_pend_r && ~miss_ready_o;
    // Buffer flags are registered: wait one cycle after any buffer strobe.
    assign sb_quiet    = ~sb_write_o && ~sb_read_o && ~sb_flush_o;

    assign dbg_state_o = state_r;

    always_comb begin
        state_n      = state_r;
        req_addr_n   = req_addr_r;
        pf_addr_n    = pf_addr_r;
        pf_active_n  = pf_active_r;
        hit_pend_n   = 1'b0;
        miss_ready_n = hit_pend_r;
        miss_data_n  = miss_data_o;
        mem_read_n   = mem_read_o;
        mem_addr_n   = mem_addr_o;
        sb_write_n   = 1'b0;
        sb_packet_n  = sb_packet_o;
        sb_read_n    = 1'b0;
        sb_flush_n   = 1'b0;

        case (state_r)
            IDLE: begin
                if (miss_accept) begin
                    req_addr_n = miss_addr_i;
                    state_n    = LOOKUP;
                end else if (pf_active_r && ~sb_full_i && sb_quiet) begin
                    mem_read_n = 1'b1;
                    mem_addr_n = pf_addr_r;
                    state_n    = PREFETCH;
                end
            end
            LOOKUP: begin
                if (head_hit) begin
                    sb_read_n   = 1'b1;
                    hit_pend_n  = 1'b1;
                    miss_data_n = head_data;
                    pf_active_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    sb_flush_n = 1'b1;
                    pf_addr_n  = req_addr_r + ADDR_WIDTH'(1);
                    mem_read_n = 1'b1;
                    mem_addr_n = req_addr_r;
                    state_n    = DEMAND;
                end
            end
            DEMAND: begin
                if (mem_ready_i && mem_read_o) begin
                    mem_read_n   = 1'b0;
                    miss_ready_n = 1'b1;
                    miss_data_n  = mem_rdata_i;
                    pf_active_n  = 1'b1;
                    state_n      = IDLE;
                end
            end
            PREFETCH: begin
                if (mem_ready_i && mem_read_o) begin
                    mem_read_n  = 1'b0;
                    sb_write_n  = 1'b1;
                    sb_packet_n = {pf_addr_r, mem_rdata_i};
                    pf_addr_n   = pf_addr_r + ADDR_WIDTH'(1);
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            req_addr_r   <= '0;
            pf_addr_r    <= '0;
            pf_active_r  <= 1'b0;
            hit_pend_r   <= 1'b0;
            miss_ready_o <= 1'b0;
            miss_data_o  <= '0;
            mem_read_o   <= 1'b0;
            mem_addr_o   <= '0;
            sb_write_o   <= 1'b0;
            sb_packet_o  <= '0;
            sb_read_o    <= 1'b0;
            sb_flush_o   <= 1'b0;
        end else begin
            state_r      <= state_n;
            req_addr_r   <= req_addr_n;
            pf_addr_r    <= pf_addr_n;
            pf_active_r  <= pf_active_n;
            hit_pend_r   <= hit_pend_n;
            miss_ready_o <= miss_ready_n;
            miss_data_o  <= miss_data_n;
            mem_read_o   <= mem_read_n;
            mem_addr_o   <= mem_addr_n;
            sb_write_o   <= sb_write_n;
            sb_packet_o  <= sb_packet_n;
            sb_read_o    <= sb_read_n;
            sb_flush_o   <= sb_flush_n;
        end
    end

endmodule
